// File: rtl/dump_sequencer_if.sv
// dump_sequencer_if: read side of the dump sequencer output FIFO.
// The sequencer presents a show-ahead entry, and the consumer pops it with the valid/ready handshake.
interface dump_sequencer_if #(
    parameter int CW     = 3,
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_cor;
    logic [1:0]        out_flags;
    logic [DATA_W-1:0] out_i;
    logic [DATA_W-1:0] out_q;

    modport master (
        output out_valid,
        output out_cor,
        output out_flags,
        output out_i,
        output out_q,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_cor,
        input  out_flags,
        input  out_i,
        input  out_q,
        output out_ready
    );
endinterface

// File: rtl/dump_sequencer.sv
// dump_sequencer: steps through the correlators of a channel on each code dump.
// It tracks the coherent and bit counters and queues every dumped I/Q pair in a small show-ahead FIFO.
module dump_sequencer #(
    parameter int COR_NUM    = 8,
    parameter int DATA_W     = 16,
    parameter int DCNT_W     = 16,
    parameter int COH_W      = 6,
    parameter int BIT_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          overflow,
    input  logic                          shift_code,
    input  logic [DCNT_W-1:0]             dump_length,
    input  logic [COH_W-1:0]              coherent_number,
    input  logic [BIT_W-1:0]              bit_length,
    input  logic                          enable_2nd_prn,
    input  logic                          state_load,
    input  logic [DCNT_W-1:0]             dump_count_i,
    output logic [DCNT_W-1:0]             dump_count_o,
    input  logic                          dumping_i,
    output logic                          dumping_o,
    input  logic [$clog2(COR_NUM)-1:0]    current_cor_i,
    output logic [$clog2(COR_NUM)-1:0]    current_cor_o,
    input  logic [COH_W-1:0]              coherent_count_i,
    output logic [COH_W-1:0]              coherent_count_o,
    input  logic [BIT_W-1:0]              bit_count_i,
    output logic [BIT_W-1:0]              bit_count_o,
    input  logic [DATA_W-1:0]             i_acc,
    input  logic [DATA_W-1:0]             q_acc,
    dump_sequencer_if.master              fifo,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_overflow,
    input  logic                          clear_status,
    output logic                          dumping_valid,
    output logic                          coherent_done,
    output logic                          overwrite_protect,
    output logic                          data_decode_valid
);
    localparam int CW = $clog2(COR_NUM);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = CW + 2 + 2 * DATA_W;
    localparam logic [CW-1:0] LAST_COR = CW'(COR_NUM - 1);

    logic              overflow_d;
    logic              last_cor;
    logic              is_data_cor;
    logic              overwrite;
    logic              new_sum;
    logic [DCNT_W-1:0] dcnt_nxt;
    logic              dcnt_wrap;
    logic [COH_W-1:0]  coh_nxt;
    logic              coh_wrap;
    logic [BIT_W-1:0]  bit_nxt;
    logic              bit_wrap;
    logic              first_seen;
    logic [CW-1:0]     first_cor;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [EW-1:0]     wr_data;
    logic [EW-1:0]     rd_data;
    logic              push;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;

    // Dump strobe, wrap detection and the entry attributes, all from pre-update state
    always_comb begin
        dumping_valid = dumping_o & overflow_d;
        last_cor      = dumping_valid & (current_cor_o == LAST_COR);
        is_data_cor   = enable_2nd_prn & (current_cor_o == '0)
                        & (bit_length != '0);
        dcnt_nxt      = dump_count_o + DCNT_W'(1);
        dcnt_wrap     = (dcnt_nxt == dump_length);
        coh_nxt       = coherent_count_o + COH_W'(1);
        coh_wrap      = (coh_nxt == coherent_number);
        bit_nxt       = bit_count_o + BIT_W'(1);
        bit_wrap      = (bit_nxt == bit_length);
        overwrite     = first_seen & (current_cor_o == first_cor)
                        & (coherent_count_o == '0) & dumping_valid;
        new_sum       = is_data_cor ? (bit_count_o == '0)
                                    : (coherent_count_o == '0);
    end

    // Delay the accumulator strobe by one cycle to line it up with the accumulator data
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) overflow_d <= 1'b0;
        else        overflow_d <= overflow;
    end

    // Sequencer counters; a state load overrides every update in the same cycle
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dump_count_o     <= '0;
            dumping_o        <= 1'b0;
            current_cor_o    <= '0;
            coherent_count_o <= '0;
            bit_count_o      <= '0;
        end else if (state_load) begin
            dump_count_o     <= dump_count_i;
            dumping_o        <= dumping_i;
            current_cor_o    <= current_cor_i;
            coherent_count_o <= coherent_count_i;
            bit_count_o      <= bit_count_i;
        end else begin
            if (shift_code)
                dump_count_o <= dcnt_wrap ? '0 : dcnt_nxt;
            if (shift_code && dcnt_wrap)
                dumping_o <= 1'b1;
            else if (last_cor)
                dumping_o <= 1'b0;
            if (last_cor)
                current_cor_o <= '0;
            else if (dumping_valid)
                current_cor_o <= current_cor_o + CW'(1);
            if (last_cor)
                coherent_count_o <= coh_wrap ? '0 : coh_nxt;
            if (dumping_valid && is_data_cor)
                bit_count_o <= bit_wrap ? '0 : bit_nxt;
        end
    end

    // Sticky status flags and tracking of the first correlator dumped after a load
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            coherent_done     <= 1'b0;
            data_decode_valid <= 1'b0;
            overwrite_protect <= 1'b0;
            first_seen        <= 1'b0;
            first_cor         <= '0;
        end else if (state_load) begin
            coherent_done     <= 1'b0;
            data_decode_valid <= 1'b0;
            overwrite_protect <= 1'b0;
            first_seen        <= 1'b0;
            first_cor         <= '0;
        end else begin
            if (dumping_valid && coh_wrap)
                coherent_done <= 1'b1;
            if (dumping_valid && is_data_cor && bit_wrap)
                data_decode_valid <= 1'b1;
            if (overwrite)
                overwrite_protect <= 1'b1;
            if (dumping_valid && !first_seen) begin
                first_seen <= 1'b1;
                first_cor  <= current_cor_o;
            end
        end
    end

    // FIFO control: a push into a full FIFO is accepted only when a pop frees a slot in the same cycle
    always_comb begin
        push    = dumping_valid;
        pop     = fifo.out_valid & fifo.out_ready;
        full    = (fifo_level == LW'(FIFO_DEPTH));
        accept  = push & (~full | pop);
        drop    = push & full & ~pop;
        wr_data = {current_cor_o, overwrite | overwrite_protect, new_sum,
                   i_acc, q_acc};
    end

    // Entry storage; it is not reset because the pointers define what is valid
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy, which wrap modulo the FIFO depth
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle wins over a clear
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)            fifo_overflow <= 1'b0;
        else if (drop)         fifo_overflow <= 1'b1;
        else if (clear_status) fifo_overflow <= 1'b0;
    end

    // Show-ahead head entry, forced to zero while the FIFO is empty
    always_comb begin
        rd_data        = mem[rd_ptr];
        fifo.out_valid = (fifo_level != '0);
        {fifo.out_cor, fifo.out_flags, fifo.out_i, fifo.out_q} =
            fifo.out_valid ? rd_data : '0;
    end
endmodule
